// File: rtl/sdram_request_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the SDRAM controller command port.
interface sdram_request_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [1:0]        cmd0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;
    logic              req1;
    logic [1:0]        cmd1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, mem_valid, mem_rdata,
        output gnt0, done0, gnt1, done1, rdata, err, busy,
        output mem_cmd, mem_addr, mem_wdata, mem_ready
    );

    modport master (
        output req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, mem_valid, mem_rdata,
        input  gnt0, done0, gnt1, done1, rdata, err, busy,
        input  mem_cmd, mem_addr, mem_wdata, mem_ready
    );
endinterface

// File: rtl/sdram_request_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between two requesters.
//  state | meaning
//  IDLE  | no transaction; sample requests and latch the winner's command
//  ISSUE | one-cycle mem_ready strobe, watchdog cleared
//  WAIT  | holding command, waiting for mem_valid or watchdog expiry
//  DONE  | one-cycle doneN pulse with err qualifier
module sdram_request_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    sdram_request_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last WAIT cycle is the one whose increment would land on TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    state_t            state_q, state_d;
    logic              owner_q;
    logic              last_q;
    logic              err_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        mem_cmd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic       any_req;
    logic       sel;
    logic [1:0] sel_cmd;
    logic       sel_legal;
    logic       timeout;

    assign any_req   = bus.req0 | bus.req1;
    assign sel       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign sel_cmd   = sel ? bus.cmd1 : bus.cmd0;
    assign sel_legal = (sel_cmd == CMD_WRITE) || (sel_cmd == CMD_READ);
    assign timeout   = (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = sel_legal ? ISSUE : DONE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_valid || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            err_q       <= 1'b0;
            wd_q        <= '0;
            mem_cmd_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    owner_q     <= sel;
                    mem_cmd_q   <= sel_cmd;
                    mem_addr_q  <= sel ? bus.addr1 : bus.addr0;
                    mem_wdata_q <= sel ? bus.wdata1 : bus.wdata0;
                    err_q       <= ~sel_legal;
                end
                ISSUE: wd_q <= '0;
                WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.mem_valid) begin
                        err_q <= 1'b0;
                        if (mem_cmd_q == CMD_READ) rdata_q <= bus.mem_rdata;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_q    <= owner_q;
                    mem_cmd_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0      = (state_q != IDLE) && !owner_q;
    assign bus.gnt1      = (state_q != IDLE) &&  owner_q;
    assign bus.done0     = (state_q == DONE) && !owner_q;
    assign bus.done1     = (state_q == DONE) &&  owner_q;
    assign bus.err       = (state_q == DONE) &&  err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_ready = (state_q == ISSUE);
    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Directed bench for sdram_request_arbiter with a small SDRAM responder and a done-event scoreboard.
module tb_sdram_request_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    sdram_request_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          port;
        logic        err;
        logic        chk_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_cnt = 0;
    int done_cnt  = 0;
    int gnt0_seen = 0;
    int valid_cyc = -1;
    bit mem_en  = 1'b1;
    bit pending = 1'b0;
    bit stray   = 1'b0;
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard and protocol monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            chk("gnt_overlap", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
            if (bus.mem_ready) ready_cnt++;
            if (bus.gnt0) gnt0_seen++;
            if (bus.done0 | bus.done1) begin
                done_cnt++;
                chk("sb_nonempty_at_done", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_port", bus.done1 ? 32'd1 : 32'd0, e.port);
                    chk("done_err", {31'd0, bus.err}, {31'd0, e.err});
                    if (e.chk_rd) chk("done_rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
                end
            end
        end
    end

    // SDRAM controller model: mem_valid in the cycle after the strobe.
    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_valid = 1'b0;
            if (stray) begin
                bus.mem_valid = 1'b1;
                stray = 1'b0;
            end else if (pending) begin
                pending = 1'b0;
                bus.mem_valid = 1'b1;
                valid_cyc = cyc;
                if (bus.mem_cmd == 2'b10) mem_model[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : '0;
            end else if (bus.mem_ready && mem_en && !rst) begin
                pending = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic gap();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input int port, input logic [1:0] cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic exp_err, input logic chk_rd,
                           input logic [DW-1:0] exp_rd, input int budget,
                           output int lat, output int nrdy);
        bit got;
        exp_t e;
        e.port = port; e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
        sb.push_back(e);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.cmd0 = cmd; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.cmd1 = cmd; bus.addr1 = addr; bus.wdata1 = wdata;
        end
        lat = 0; nrdy = 0; got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            if (bus.mem_ready) begin
                nrdy++;
                chk("strobe_addr", {7'd0, bus.mem_addr}, {7'd0, addr});
                chk("strobe_wdata", {16'd0, bus.mem_wdata}, {16'd0, wdata});
                chk("strobe_cmd", {30'd0, bus.mem_cmd}, {30'd0, cmd});
            end
            if (bus.done0 | bus.done1) got = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int lat, nrdy, r0, ndone, d0, k;
        bit found;
        bus.req0 = 1'b0; bus.cmd0 = 2'b00; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.cmd1 = 2'b00; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
        chk("rst_done0", {31'd0, bus.done0}, 32'd0);
        chk("rst_done1", {31'd0, bus.done1}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_mem_cmd", {30'd0, bus.mem_cmd}, 32'd0);
        chk("rst_mem_addr", {7'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        rst = 1'b0;
        gap();

        // Single write from port 0
        run_txn(0, 2'b10, 25'h0FFFF, 16'hAAAA, 1'b0, 1'b0, 16'h0, 20, lat, nrdy);
        chk("wr_latency", lat, 32'd3);
        chk("wr_strobes", nrdy, 32'd1);
        chk("valid_to_done", cyc - valid_cyc, 32'd1);
        @(posedge clk);
        gnt0_seen = 0;
        @(negedge clk);

        // Read back from port 1
        run_txn(1, 2'b01, 25'h0FFFF, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 20, lat, nrdy);
        chk("rd_latency", lat, 32'd3);
        chk("rd_rdata", {16'd0, bus.rdata}, 32'h0000AAAA);
        @(posedge clk);
        chk("rd_gnt0_quiet", gnt0_seen, 32'd0);
        @(negedge clk);

        // Contention: last grant was port 1, so order is 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.port = i % 2; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = '0;
            sb.push_back(e);
        end
        r0 = ready_cnt;
        bus.req0 = 1'b1; bus.cmd0 = 2'b10; bus.addr0 = 25'h100; bus.wdata0 = 16'h1111;
        bus.req1 = 1'b1; bus.cmd1 = 2'b10; bus.addr1 = 25'h200; bus.wdata1 = 16'h2222;
        ndone = 0; k = 0;
        while (ndone < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.done0 | bus.done1) ndone++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        gap();
        chk("cont_dones", ndone, 32'd4);
        chk("cont_strobes", ready_cnt - r0, 32'd4);
        chk("cont_rdata_hold", {16'd0, bus.rdata}, 32'h0000AAAA);
        gap();

        run_txn(1, 2'b01, 25'h200, 16'h0000, 1'b0, 1'b1, 16'h2222, 20, lat, nrdy);
        gap();

        // Illegal command
        run_txn(0, 2'b11, 25'h123, 16'h5555, 1'b1, 1'b0, 16'h0, 10, lat, nrdy);
        chk("illegal_latency", lat, 32'd1);
        chk("illegal_strobes", nrdy, 32'd0);
        gap();

        // Watchdog timeout
        mem_en = 1'b0;
        run_txn(0, 2'b10, 25'h7, 16'h7777, 1'b1, 1'b0, 16'h0, TO + 10, lat, nrdy);
        chk("timeout_latency", lat, TO + 1);
        chk("timeout_strobes", nrdy, 32'd1);
        chk("timeout_rdata_hold", {16'd0, bus.rdata}, 32'h00002222);
        mem_en = 1'b1;
        gap();

        // Reset while in WAIT, then a stray mem_valid
        mem_en = 1'b0;
        bus.req0 = 1'b1; bus.cmd0 = 2'b01; bus.addr0 = 25'h0FFFF; bus.wdata0 = 16'h0;
        found = 1'b0; k = 0;
        while (!found && k < 10) begin
            @(negedge clk);
            k++;
            if (bus.mem_ready) found = 1'b1;
        end
        chk("abort_strobe_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        d0 = done_cnt;
        @(negedge clk);
        stray = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("abort_mem_cmd", {30'd0, bus.mem_cmd}, 32'd0);
        chk("abort_rdata", {16'd0, bus.rdata}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        mem_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
